// File: rtl/enoc_switch_allocator.sv
// Per-output round-robin switch allocator for an ENoC router: picks one input per output,
// drives crossbar selects and queue pops, and holds a grant while the downstream side stalls.
module enoc_switch_allocator #(
  parameter int N     = 5,
  parameter int M     = 5,
  parameter int SEL_W = $clog2(N)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [0:N-1][0:M-1]     i_req,
  input  logic [0:M-1]            i_en,
  output logic [0:N-1][0:M-1]     o_grant,
  output logic [0:M-1][SEL_W-1:0] o_sel,
  output logic [0:M-1]            o_data_val,
  output logic [0:N-1]            o_pop
);

  typedef enum logic {FREE = 1'b0, HELD = 1'b1} state_t;

  state_t           state     [M];
  state_t           state_nxt [M];
  logic [SEL_W-1:0] ptr       [M];
  logic [SEL_W-1:0] ptr_nxt   [M];
  logic [SEL_W-1:0] owner     [M];
  logic [SEL_W-1:0] owner_nxt [M];

  logic [0:N-1][0:M-1] req_lo;
  logic [SEL_W-1:0]    win     [M];
  logic                win_ok  [M];
  logic [SEL_W-1:0]    cur_sel [M];
  logic                cur_val [M];

  function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] v);
    return (v == SEL_W'(N - 1)) ? '0 : v + SEL_W'(1);
  endfunction

  function automatic logic [SEL_W-1:0] add_mod(input logic [SEL_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N) s = s - N;
    return SEL_W'(s);
  endfunction

  // Multi-hot requests collapse to their lowest output, so an input never wins two outputs.
  always_comb begin
    req_lo = '0;
    for (int n = 0; n < N; n++) begin
      for (int m = 0; m < M; m++) begin
        if (i_req[n][m] && !(|req_lo[n])) req_lo[n][m] = 1'b1;
      end
    end
  end

  always_comb begin
    for (int m = 0; m < M; m++) begin
      win_ok[m] = 1'b0;
      win[m]    = '0;
      for (int k = 0; k < N; k++) begin
        if (!win_ok[m] && req_lo[add_mod(ptr[m], k)][m]) begin
          win_ok[m] = 1'b1;
          win[m]    = add_mod(ptr[m], k);
        end
      end
    end
  end

  // Decision and next state: a held owner bypasses the round-robin search entirely.
  always_comb begin
    for (int m = 0; m < M; m++) begin
      state_nxt[m] = state[m];
      ptr_nxt[m]   = ptr[m];
      owner_nxt[m] = owner[m];
      cur_sel[m]   = '0;
      cur_val[m]   = 1'b0;
      if (state[m] == HELD) begin
        if (req_lo[owner[m]][m]) begin
          cur_val[m] = 1'b1;
          cur_sel[m] = owner[m];
          if (i_en[m]) begin
            ptr_nxt[m]   = wrap_inc(owner[m]);
            state_nxt[m] = FREE;
          end
        end else begin
          state_nxt[m] = FREE;
        end
      end else if (win_ok[m]) begin
        cur_val[m] = 1'b1;
        cur_sel[m] = win[m];
        if (i_en[m]) begin
          ptr_nxt[m] = wrap_inc(win[m]);
        end else begin
          state_nxt[m] = HELD;
          owner_nxt[m] = win[m];
        end
      end
    end
  end

  always_comb begin
    o_grant    = '0;
    o_sel      = '0;
    o_data_val = '0;
    o_pop      = '0;
    for (int m = 0; m < M; m++) begin
      if (!reset && cur_val[m]) begin
        o_data_val[m]          = 1'b1;
        o_sel[m]               = cur_sel[m];
        o_grant[cur_sel[m]][m] = 1'b1;
        if (i_en[m]) o_pop[cur_sel[m]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int m = 0; m < M; m++) begin
      if (reset) begin
        state[m] <= FREE;
        ptr[m]   <= '0;
        owner[m] <= '0;
      end else begin
        state[m] <= state_nxt[m];
        ptr[m]   <= ptr_nxt[m];
        owner[m] <= owner_nxt[m];
      end
    end
  end

endmodule

// File: tb/tb_enoc_switch_allocator.sv
// Bench for enoc_switch_allocator: directed scenarios plus random traffic, all compared
// against a per-output behavioural model of priority pointers and held owners.
module tb_enoc_switch_allocator;
  localparam int N     = 5;
  localparam int M     = 5;
  localparam int SEL_W = $clog2(N);

  logic                    clk = 1'b0;
  logic                    reset;
  logic [0:N-1][0:M-1]     i_req;
  logic [0:M-1]            i_en;
  logic [0:N-1][0:M-1]     o_grant;
  logic [0:M-1][SEL_W-1:0] o_sel;
  logic [0:M-1]            o_data_val;
  logic [0:N-1]            o_pop;

  enoc_switch_allocator #(.N(N), .M(M), .SEL_W(SEL_W)) dut (
    .clk(clk), .reset(reset), .i_req(i_req), .i_en(i_en),
    .o_grant(o_grant), .o_sel(o_sel), .o_data_val(o_data_val), .o_pop(o_pop)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int m_ptr [M];
  bit m_held[M];
  int m_own [M];
  int nx_ptr [M];
  bit nx_held[M];
  int nx_own [M];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs, compare all outputs to the model, and prepare the model's next state.
  task automatic step(input logic rst, input logic [0:N-1][0:M-1] req, input logic [0:M-1] en);
    logic [0:N-1][0:M-1]     eg;
    logic [0:M-1][SEL_W-1:0] es;
    logic [0:M-1]            ev;
    logic [0:N-1]            ep;
    int first[N];
    int w;
    reset = rst;
    i_req = req;
    i_en  = en;
    #1;
    eg = '0; es = '0; ev = '0; ep = '0;
    for (int n = 0; n < N; n++) begin
      first[n] = -1;
      for (int m = 0; m < M; m++) if (req[n][m] && first[n] < 0) first[n] = m;
    end
    for (int m = 0; m < M; m++) begin
      nx_ptr[m] = m_ptr[m]; nx_held[m] = m_held[m]; nx_own[m] = m_own[m];
      if (rst) begin
        nx_ptr[m] = 0; nx_held[m] = 0; nx_own[m] = 0;
      end else begin
        w = -1;
        if (m_held[m]) begin
          if (first[m_own[m]] == m) w = m_own[m];
          else nx_held[m] = 0;
        end else begin
          for (int k = 0; k < N; k++)
            if (w < 0 && first[(m_ptr[m] + k) % N] == m) w = (m_ptr[m] + k) % N;
        end
        if (w >= 0) begin
          ev[m] = 1'b1; es[m] = SEL_W'(w); eg[w][m] = 1'b1;
          if (en[m]) begin
            ep[w] = 1'b1; nx_ptr[m] = (w + 1) % N; nx_held[m] = 0;
          end else begin
            nx_held[m] = 1; nx_own[m] = w;
          end
        end
      end
    end
    check("grant", 64'(o_grant), 64'(eg));
    check("sel",   64'(o_sel),   64'(es));
    check("valid", 64'(o_data_val), 64'(ev));
    check("pop",   64'(o_pop),   64'(ep));
  endtask

  task automatic tick();
    @(posedge clk);
    for (int m = 0; m < M; m++) begin
      m_ptr[m] = nx_ptr[m]; m_held[m] = nx_held[m]; m_own[m] = nx_own[m];
    end
    @(negedge clk);
  endtask

  function automatic logic [0:N-1][0:M-1] rq(input int n, input int m);
    logic [0:N-1][0:M-1] r;
    r = '0;
    r[n][m] = 1'b1;
    return r;
  endfunction

  logic [0:N-1][0:M-1] r;
  logic [0:M-1]        en_all;
  logic [0:M-1]        en_v;
  int                  seq[5];

  initial begin
    en_all = '1;
    seq = '{0, 2, 4, 0, 2};
    for (int m = 0; m < M; m++) begin
      m_ptr[m] = 0; m_held[m] = 0; m_own[m] = 0;
    end
    reset = 1'b1; i_req = '0; i_en = '0;
    @(negedge clk);

    // Reset with every request and enable high.
    r = '1;
    for (int c = 0; c < 2; c++) begin
      step(1'b1, r, en_all);
      check("rst_val", 64'(o_data_val), 64'd0);
      check("rst_pop", 64'(o_pop), 64'd0);
      tick();
    end
    step(1'b0, r, en_all);
    check("first_sel0", 64'(o_sel[0]), 64'd0);
    check("first_grant00", 64'(o_grant[0][0]), 64'd1);
    tick();

    // Round-robin fairness on output 1.
    step(1'b1, '0, en_all); tick();
    for (int c = 0; c < 5; c++) begin
      r = rq(0, 1) | rq(2, 1) | rq(4, 1);
      step(1'b0, r, en_all);
      check("rr_sel1", 64'(o_sel[1]), 64'(seq[c]));
      check("rr_pop_one", 64'($countones(o_pop)), 64'd1);
      check("rr_pop_who", 64'(o_pop[seq[c]]), 64'd1);
      tick();
    end

    // Stall hold on output 2.
    step(1'b1, '0, en_all); tick();
    en_v = en_all; en_v[2] = 1'b0;
    step(1'b0, rq(3, 2), en_v);
    check("hold_first_sel", 64'(o_sel[2]), 64'd3);
    tick();
    for (int c = 0; c < 4; c++) begin
      step(1'b0, rq(3, 2) | rq(1, 2), en_v);
      check("hold_sel", 64'(o_sel[2]), 64'd3);
      check("hold_nopop", 64'(o_pop), 64'd0);
      tick();
    end
    step(1'b0, rq(3, 2) | rq(1, 2), en_all);
    check("release_pop3", 64'(o_pop[3]), 64'd1);
    check("release_pop_one", 64'($countones(o_pop)), 64'd1);
    tick();
    step(1'b0, rq(3, 2) | rq(1, 2), en_all);
    check("after_release_sel", 64'(o_sel[2]), 64'd1);
    tick();

    // Parallel outputs.
    step(1'b0, rq(0, 2) | rq(1, 3) | rq(2, 0), en_all);
    check("par_pops", 64'($countones(o_pop)), 64'd3);
    check("par_sel2", 64'(o_sel[2]), 64'd0);
    check("par_sel3", 64'(o_sel[3]), 64'd1);
    check("par_sel0", 64'(o_sel[0]), 64'd2);
    tick();

    // Wrap-around on output 4 and multi-hot masking.
    step(1'b1, '0, en_all); tick();
    step(1'b0, rq(3, 4), en_all); tick();
    step(1'b0, rq(4, 4) | rq(0, 4), en_all);
    check("wrap_sel_a", 64'(o_sel[4]), 64'd4);
    tick();
    step(1'b0, rq(4, 4) | rq(0, 4), en_all);
    check("wrap_sel_b", 64'(o_sel[4]), 64'd0);
    tick();
    step(1'b0, rq(1, 1) | rq(1, 3), en_all);
    check("mh_grant11", 64'(o_grant[1][1]), 64'd1);
    check("mh_val3", 64'(o_data_val[3]), 64'd0);
    tick();

    // Reset in the middle of a hold on output 0.
    en_v = en_all; en_v[0] = 1'b0;
    step(1'b0, rq(2, 0), en_v); tick();
    step(1'b1, rq(2, 0), en_all);
    check("rsthold_nopop", 64'(o_pop), 64'd0);
    tick();
    step(1'b0, rq(0, 0) | rq(1, 0) | rq(2, 0), en_all);
    check("rsthold_free_sel", 64'(o_sel[0]), 64'd0);
    tick();

    // Random traffic.
    for (int c = 0; c < 800; c++) begin
      r = '0;
      for (int n = 0; n < N; n++) begin
        if ($urandom_range(0, 2) != 0) begin
          if ($urandom_range(0, 7) == 0) r[n] = M'($urandom);
          else r[n][$urandom_range(0, M - 1)] = 1'b1;
        end
      end
      en_v = M'($urandom);
      step(($urandom_range(0, 59) == 0), r, en_v);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/enoc_switch_allocator.md
# enoc_switch_allocator

- Per-output round-robin switch allocator for an ENoC router.
- Decides which input queue may drive each router output port every cycle.
- Holds a grant stable while the downstream router or node withholds enable.
- Sits between the router's input queues and its crossbar, driving the crossbar select lines and input-queue pop strobes under the network's valid/enable protocol.

## Interface

Parameters:
- N, 5: number of router input ports (0 = local node, 1 = N, 2 = E, 3 = S, 4 = W).
- M, 5: number of router output ports, same numbering.
- SEL_W, $clog2(N): width of each crossbar select field.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- i_req  input  [0:N-1][0:M-1]  per input, one-hot output request from head-of-queue packet; all-zero = no request.
- i_en  input  [0:M-1]  downstream enable per output; a transfer occurs on output m when o_data_val[m] and i_en[m] are both high.
- o_grant  output  [0:N-1][0:M-1]  input n currently granted output m.
- o_sel  output  [0:M-1][SEL_W-1:0]  crossbar select (winning input index) per output.
- o_data_val  output  [0:M-1]  output m is driven by a granted input.
- o_pop  output  [0:N-1]  dequeue strobe to input queue n; high exactly on a transfer cycle of its granted output.

## Operation

- Requests with more than one bit set are masked to the lowest-index set bit before arbitration. An input is therefore granted at most one output, so no input-side conflict exists.
- Per output m state: ptr[m] (round-robin priority, 0..N-1) and a two-state FSM with state FREE or HELD(owner[m]).
- FREE, arbitration:
  - Winner = first requesting input n (i_req[n][m]) searching ptr[m], ptr[m]+1, … mod N.
  - If no requester: o_data_val[m]=0, o_sel[m]=0, no state change.
  - Winner and i_en[m]=1: transfer. o_pop[winner]=1, ptr[m] <= (winner+1) mod N, stay FREE.
  - Winner and i_en[m]=0: no transfer. Go HELD, owner[m] <= winner, ptr unchanged.
- HELD(owner):
  - Only the owner is granted, regardless of other requests or ptr.
  - Owner requesting and i_en[m]=1: transfer. o_pop[owner]=1, ptr[m] <= (owner+1) mod N, go FREE.
  - Owner requesting and i_en[m]=0: stay HELD.
  - Owner request drops (protocol error): o_data_val[m]=0, go FREE, ptr unchanged.
- Combinational relations:
  - o_grant[n][m] = 1 for the selected input of each output with o_data_val[m]=1.
  - o_sel[m] = that input index.
  - o_pop[n] = OR over m of (o_grant[n][m] & i_en[m]).
- Wrap-around: ptr at N-1 advances to 0. Winner search wraps modulo N.

## Timing

- Grant, select, valid and pop are combinational from i_req, i_en and registered state. There is zero-cycle latency from request to grant in FREE.
- ptr, FSM state and owner update on the rising clk edge following the decision.
- Sustained throughput: one transfer per output per cycle. Up to M concurrent transfers per cycle.
- While reset=1: o_grant, o_data_val and o_pop are forced to 0, and o_sel is forced to 0.
- At the first edge with reset=1: all ptr <= 0, all FSMs <= FREE, owner <= 0.
- Reset asserted mid-HELD abandons the hold with no pop. The input queue retains its packet.
- Simultaneous events:
  - A new requester arriving while HELD is ignored until release.
  - i_en rising in the same cycle as the first grant transfers immediately, with no HELD cycle.

## Test plan

- Reset: assert reset with all i_req set and i_en=all 1. Required: o_data_val=0, o_pop=0 during reset. After release, output 0 is granted first to input 0 (ptr=0).
- Round-robin fairness: inputs 0, 2 and 4 continuously request output 1, i_en[1]=1. Required grant sequence 0, 2, 4, 0, 2, with one o_pop per cycle and each input within every 3 cycles.
- Stall hold:
  - Cycle 0: input 3 requests output 2 with i_en[2]=0. Required: HELD, owner 3.
  - Cycle 1: input 1 also requests. Required: grant stays on input 3 while i_en[2]=0 for 4 cycles, no pops.
  - When i_en[2]=1: o_pop[3]=1 for exactly 1 cycle, then input 1 is granted with ptr[2]=4.
- Parallel outputs: input 0 requests output 2, input 1 requests output 3, input 2 requests output 0, all i_en=1. Required: three grants and three pops in the same cycle, with o_sel[2]=0, o_sel[3]=1, o_sel[0]=2.
- Wrap and multi-hot:
  - ptr[4]=4 with inputs 4 and 0 requesting output 4. Required order 4 then 0.
  - Input 1 requests outputs 1 and 3 simultaneously. Required: treated as a request for output 1 only.
- Reset mid-hold: HELD on output 0 (owner 2), then assert reset for 1 cycle. Required: no o_pop. After release, ptr[0]=0 and the FSM is FREE.
